multicycle_ctrl: RTL and testbench

//   Main control FSM of the multicycle RV32I core. Consumes opcode/funct3/funct7 from the instruction decoder,

---
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (trap and halt on illegal opcode / R-type funct7).
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [3:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       bus_err,
    output logic       trap
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t        state;
    logic [6:0]    op_q;
    logic [2:0]    f3_q;
    logic [6:0]    f7_q;
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;
    logic          timeout;
    logic          alt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic          trap_q;
`endif

    // SUB/SRA/SRAI are the only encodings carrying funct7 = 0100000
    assign alt = (f7_q == F7_ALT);

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic use_alt, input logic is_r);
        case (f3)
            3'd0:    return (is_r && use_alt) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return use_alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign timeout = (TIMEOUT_CYC != 0) && (state == S_FETCH || state == S_MEM) && !mem_ready
                     && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            if ((state == S_FETCH || state == S_MEM) && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_DECODE: begin
                    op_q  <= opcode;
                    f3_q  <= funct3;
                    f7_q  <= funct7;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            if (f7_q != 7'b0000000 && f7_q != F7_ALT) begin
                                trap_q <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                state <= S_WB;
                            end
`else
                            state <= S_WB;
`endif
                        end
                        OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state <= S_WB;
                        OP_LOAD, OP_STORE:                       state <= S_MEM;
                        OP_BRANCH:                               state <= S_FETCH;
                        OP_SYSTEM:                               state <= S_HALT;
                        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            trap_q <= 1'b1;
                            state  <= S_HALT;
`else
                            state <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (op_q == OP_STORE) ? S_FETCH : S_WB;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so an in-flight request drops the moment reset asserts
    always_comb begin
        mem_req   = 1'b0;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: alu_op = alu_from_f3(f3_q, alt, 1'b1);
                        OP_I: begin
                            alu_b_sel = 1'b1;
                            alu_op    = alu_from_f3(f3_q, alt, 1'b0);
                        end
                        OP_LUI: begin
                            alu_b_sel = 1'b1;
                            alu_op    = ALU_PASS_B;
                        end
                        OP_AUIPC: begin
                            alu_a_sel = 1'b1;
                            alu_b_sel = 1'b1;
                        end
                        OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
                        OP_BRANCH: begin
                            alu_op = ALU_SUB;
                            pc_we  = br_taken;
                            pc_src = {1'b0, br_taken};
                        end
                        OP_JAL: begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                        OP_JALR: begin
                            alu_b_sel = 1'b1;
                            pc_we     = 1'b1;
                            pc_src    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    mem_we  = (op_q == OP_STORE);
                end
                S_WB: begin
                    reg_we = 1'b1;
                    if (op_q == OP_LOAD)
                        wb_sel = 2'd1;
                    else if (op_q == OP_JAL || op_q == OP_JALR)
                        wb_sel = 2'd2;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_err = bus_err_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Honours CTRL_ILLEGAL_TRAP_EN when the design is built with it.
module tb_multicycle_ctrl;
    localparam int T = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req, mem_sel, mem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_a_sel, alu_b_sel;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       halted, bus_err, trap;
    logic [18:0] obs;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
        .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .halted(halted), .bus_err(bus_err), .trap(trap)
    );

    assign obs = {mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
                  alu_op, reg_we, wb_sel, halted, bus_err, trap};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference model: per-instruction phase lists built from the latency/strobe rules
    typedef struct {
        logic        mr;
        logic        bt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [18:0] exp;
        int          ph;
        int          idx;
    } cyc_t;

    cyc_t       q[$];
    logic       m_halt, m_berr, m_trap;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    int         instr_n = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic alt;
        alt = f7[5] && (f3 == 3'd5 || (f3 == 3'd0 && op == OP_R));
        return ALU_BASE[f3] + {3'b000, alt};
    endfunction

    function automatic logic [18:0] ev(input int req, input int sel, input int we, input int irwe,
                                       input int pcwe, input int pcsrc, input int a, input int b,
                                       input int alu, input int rwe, input int wbs);
        return {1'(req), 1'(sel), 1'(we), 1'(irwe), 1'(pcwe), 2'(pcsrc), 1'(a), 1'(b),
                4'(alu), 1'(rwe), 2'(wbs), m_halt, m_berr, m_trap};
    endfunction

    task automatic add(input logic mr, input logic bt, input logic real_op, input logic [18:0] e, input int ph);
        cyc_t c;
        c.mr = mr; c.bt = bt; c.exp = e; c.ph = ph; c.idx = instr_n;
        if (real_op) begin
            c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
        end else begin
            c.op = 7'($urandom); c.f3 = 3'($urandom); c.f7 = 7'($urandom);
        end
        q.push_back(c);
    endtask

    task automatic add_halt();
        add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0), 5);
        add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0), 5);
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic br, input int fd, input int md);
        int alu;
        int st;
        alu = int'(ref_alu(op, f3, f7));
        st = (op == OP_STORE) ? 1 : 0;
        instr_n++;
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        for (int i = 0; i < fd; i++) begin
            add(1'b0, rb(), 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0), 0);
            if (i == T - 1) begin
                m_berr = 1'b1; m_halt = 1'b1;
                add_halt();
                return;
            end
        end
        add(1'b1, rb(), 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0), 0);
        add(rb(), rb(), 1'b1, ev(0,0,0,0,0,0,0,0,0,0,0), 1);
        case (op)
            OP_R, OP_I: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,(op == OP_I) ? 1 : 0,alu,0,0), 2);
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,0), 4);
            end
            OP_LUI: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,1,10,0,0), 2);
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,0), 4);
            end
            OP_AUIPC: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,1,1,0,0,0), 2);
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,0), 4);
            end
            OP_LOAD, OP_STORE: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,1,0,0,0), 2);
                for (int i = 0; i < md; i++) begin
                    add(1'b0, rb(), 1'b0, ev(1,1,st,0,0,0,0,0,0,0,0), 3);
                    if (i == T - 1) begin
                        m_berr = 1'b1; m_halt = 1'b1;
                        add_halt();
                        return;
                    end
                end
                add(1'b1, rb(), 1'b0, ev(1,1,st,0,0,0,0,0,0,0,0), 3);
                if (st == 0)
                    add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,1), 4);
            end
            OP_BRANCH: add(rb(), br, 1'b0, ev(0,0,0,0,br,br,0,0,1,0,0), 2);
            OP_JAL: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,1,1,0,0,0,0,0), 2);
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,2), 4);
            end
            OP_JALR: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,1,2,0,1,0,0,0), 2);
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,1,2), 4);
            end
            OP_SYSTEM: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0), 2);
                m_halt = 1'b1;
                add_halt();
            end
            default: begin
                add(rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,0,0,0,0), 2);
`ifdef CTRL_ILLEGAL_TRAP_EN
                m_trap = 1'b1; m_halt = 1'b1;
                add_halt();
`endif
            end
        endcase
    endtask

    // Entry/exit invariant for all sequences: just past a falling edge, inputs not yet driven
    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.mr; br_taken = c.bt; opcode = c.op; funct3 = c.f3; funct7 = c.f7;
            #1;
            check($sformatf("instr%0d_ph%0d", c.idx, c.ph), 32'(obs), 32'(c.exp));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        check("reset_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_halt = 1'b0; m_berr = 1'b0; m_trap = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       br;
        int         lat;
        logic [8:0] ex;
        logic [3:0] last;
    } tv_t;

    tv_t tv[$];

    function automatic logic [8:0] exv(input int a, input int b, input int alu, input int pcwe, input int pcsrc);
        return {1'(a), 1'(b), 4'(alu), 1'(pcwe), 2'(pcsrc)};
    endfunction

    function automatic logic [3:0] lv(input int rwe, input int wbs, input int we);
        return {1'(rwe), 2'(wbs), 1'(we)};
    endfunction

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [11];
        logic [6:0] op, f7;
        logic [2:0] f3;
        int fd, md;

        tv.push_back('{OP_R,      3'd0, 7'h00, 1'b0, 4, exv(0,0,0,0,0),  lv(1,0,0)});
        tv.push_back('{OP_R,      3'd0, 7'h20, 1'b0, 4, exv(0,0,1,0,0),  lv(1,0,0)});
        tv.push_back('{OP_R,      3'd5, 7'h20, 1'b0, 4, exv(0,0,7,0,0),  lv(1,0,0)});
        tv.push_back('{OP_R,      3'd3, 7'h00, 1'b0, 4, exv(0,0,4,0,0),  lv(1,0,0)});
        tv.push_back('{OP_I,      3'd0, 7'h20, 1'b0, 4, exv(0,1,0,0,0),  lv(1,0,0)});
        tv.push_back('{OP_I,      3'd5, 7'h20, 1'b0, 4, exv(0,1,7,0,0),  lv(1,0,0)});
        tv.push_back('{OP_I,      3'd7, 7'h55, 1'b0, 4, exv(0,1,9,0,0),  lv(1,0,0)});
        tv.push_back('{OP_LUI,    3'd2, 7'h11, 1'b0, 4, exv(0,1,10,0,0), lv(1,0,0)});
        tv.push_back('{OP_AUIPC,  3'd1, 7'h00, 1'b0, 4, exv(1,1,0,0,0),  lv(1,0,0)});
        tv.push_back('{OP_JAL,    3'd0, 7'h00, 1'b0, 4, exv(0,0,0,1,1),  lv(1,2,0)});
        tv.push_back('{OP_JALR,   3'd0, 7'h00, 1'b0, 4, exv(0,1,0,1,2),  lv(1,2,0)});
        tv.push_back('{OP_BRANCH, 3'd0, 7'h00, 1'b1, 3, exv(0,0,1,1,1),  lv(0,0,0)});
        tv.push_back('{OP_BRANCH, 3'd0, 7'h00, 1'b0, 3, exv(0,0,1,0,0),  lv(0,0,0)});
        tv.push_back('{OP_LOAD,   3'd2, 7'h00, 1'b0, 5, exv(0,1,0,0,0),  lv(1,1,0)});
        tv.push_back('{OP_STORE,  3'd2, 7'h00, 1'b0, 4, exv(0,1,0,0,0),  lv(0,0,1)});
`ifndef CTRL_ILLEGAL_TRAP_EN
        tv.push_back('{7'b0000000, 3'd0, 7'h00, 1'b0, 3, exv(0,0,0,0,0), lv(0,0,0)});
`endif

        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; br_taken = 1'b0; mem_ready = 1'b0;
        m_halt = 1'b0; m_berr = 1'b0; m_trap = 1'b0;
        @(negedge clk);
        do_reset();

        foreach (tv[k]) begin
            opcode = tv[k].op; funct3 = tv[k].f3; funct7 = tv[k].f7;
            br_taken = tv[k].br; mem_ready = 1'b1;
            for (int c = 0; c < tv[k].lat; c++) begin
                #1;
                if (c == 0)
                    check($sformatf("tbl%0d_fetch", k), 32'({mem_req, mem_sel, ir_we, pc_we, pc_src}), 32'(6'b101100));
                if (c == 2)
                    check($sformatf("tbl%0d_exec", k), 32'({alu_a_sel, alu_b_sel, alu_op, pc_we, pc_src}), 32'(tv[k].ex));
                if (c == tv[k].lat - 1)
                    check($sformatf("tbl%0d_last", k), 32'({reg_we, wb_sel, mem_we}), 32'(tv[k].last));
                @(negedge clk);
            end
        end

        // LW then SW with memory answering after 3 wait cycles
        build(OP_LOAD, 3'd2, 7'h00, 1'b0, 0, 3);
        build(OP_STORE, 3'd2, 7'h00, 1'b0, 1, 3);
        play();

        // Fetch watchdog: 4 cycles without mem_ready
        for (int i = 0; i < T; i++) begin
            mem_ready = 1'b0;
            #1;
            check($sformatf("wd_wait%0d", i), 32'({mem_req, mem_sel, bus_err, halted}), 32'(4'b1000));
            @(negedge clk);
        end
        #1;
        check("wd_expired", 32'({mem_req, bus_err, halted}), 32'(3'b011));
        rst = 1'b1;
        #1;
        check("wd_rst_clears", 32'({bus_err, halted}), 32'(2'b00));
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("wd_back_in_fetch", 32'({mem_req, mem_sel, halted}), 32'(3'b100));
        @(negedge clk);
        do_reset();

        // Reset in the middle of a data access
        opcode = OP_LOAD; funct3 = 3'd2; funct7 = 7'h00; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid_mem_active", 32'({mem_req, mem_sel}), 32'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_mem_drop", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst_mid_mem_fetch", 32'({mem_req, mem_sel, reg_we, ir_we}), 32'(4'b1000));
        @(negedge clk);
        do_reset();

        // ECALL halts
        build(OP_SYSTEM, 3'd0, 7'h00, 1'b0, 0, 0);
        play();
        mem_ready = 1'b1;
        #1;
        check("ecall_halted", 32'({halted, mem_req, ir_we}), 32'(3'b100));
        @(negedge clk);
        do_reset();

        // All-zero opcode
        build(7'b0000000, 3'd0, 7'h00, 1'b0, 0, 0);
        play();
        mem_ready = 1'b0;
        #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("opcode0_trap", 32'({trap, halted, mem_req}), 32'(3'b110));
`else
        check("opcode0_nop", 32'({trap, halted, mem_req}), 32'(3'b001));
`endif
        @(negedge clk);
        do_reset();

        ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE};
        for (int n = 0; n < 250; n++) begin
            op = ops[$urandom_range(0, 10)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if (op == OP_R || (op == OP_I && f3 == 3'd5))
                f7 = rb() ? 7'h20 : 7'h00;
            fd = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
            md = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
            build(op, f3, f7, rb(), fd, md);
            play();
            if (m_halt)
                do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
